// File: rtl/tree_seq_pkg.sv
// Shared FSM state type and accumulator width helper for the tree-sum job controller.
package tree_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Wide enough that a full job of maximal-magnitude lanes can never wrap.
  function automatic int acc_w(input int in_w, input int lanes, input int chunks);
    return in_w + $clog2(lanes) + $clog2(chunks);
  endfunction

endpackage

// File: rtl/pipe_adder_tree.sv
// Registered pairwise signed adder tree: an input register level, then one adder level per
// halving, so a vector captured at edge k appears on o_sum after edge k+$clog2(LANES).
module pipe_adder_tree
  import tree_seq_pkg::*;
#(
  parameter int LANES = 16,
  parameter int IN_W  = 8
) (
  input  logic                          clk,
  input  logic [LANES*IN_W-1:0]         i_data,
  output logic [IN_W+$clog2(LANES)-1:0] o_sum
);

  localparam int L = $clog2(LANES);

  for (genvar n = 0; n <= L; n++) begin : g_lvl
    localparam int W   = IN_W + n;
    localparam int CNT = LANES >> n;
    logic [W-1:0] r_node [CNT];

    if (n == 0) begin : g_in
      // Capture the raw lanes; data only, validity is tracked by the controller.
      always_ff @(posedge clk) begin
        for (int j = 0; j < CNT; j++) begin
          r_node[j] <= i_data[j*IN_W +: IN_W];
        end
      end
    end else begin : g_add
      // Each level grows by one bit so the pairwise sign-extended add cannot overflow.
      always_ff @(posedge clk) begin
        for (int j = 0; j < CNT; j++) begin
          r_node[j] <= {g_lvl[n-1].r_node[2*j][W-2],   g_lvl[n-1].r_node[2*j]} +
                       {g_lvl[n-1].r_node[2*j+1][W-2], g_lvl[n-1].r_node[2*j+1]};
        end
      end
    end
  end

  assign o_sum = g_lvl[L].r_node[0];

endmodule

// File: rtl/tree_sum_sequencer.sv
// Job controller streaming chunks through pipe_adder_tree and accumulating one dot product.
// Define TSS_SAT_EN to clamp the result to OUT_W bits and expose out_ovf; otherwise it wraps.
module tree_sum_sequencer
  import tree_seq_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int IN_W   = 8,
  parameter int CHUNKS = 256,
  parameter int OUT_W  = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [$clog2(CHUNKS)-1:0] job_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*IN_W-1:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_sum,
`ifdef TSS_SAT_EN
  output logic                      out_ovf,
`endif
  output logic                      busy
);

  localparam int L      = $clog2(LANES);
  localparam int TREE_W = IN_W + L;
  localparam int ACC_W  = acc_w(IN_W, LANES, CHUNKS);
  localparam int CNT_W  = $clog2(CHUNKS);

  state_t            r_state;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_cnt;
  logic [L:0]        r_vpipe;
  logic [ACC_W-1:0]  r_acc;
  logic              r_job_ready;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic [OUT_W-1:0]  r_out_sum;

  logic [TREE_W-1:0] w_tree;
  logic              w_beat;
  logic [ACC_W-1:0]  w_acc_next;
  logic [OUT_W-1:0]  w_out_sum;

  pipe_adder_tree #(
    .LANES (LANES),
    .IN_W  (IN_W)
  ) u_tree (
    .clk    (clk),
    .i_data (in_data),
    .o_sum  (w_tree)
  );

  assign w_beat     = in_valid & r_in_ready;
  assign w_acc_next = r_acc + (r_vpipe[L] ? {{(ACC_W-TREE_W){w_tree[TREE_W-1]}}, w_tree}
                                          : {ACC_W{1'b0}});

`ifdef TSS_SAT_EN
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  logic [ACC_W-OUT_W:0] w_hi;
  logic                 w_ovf;
  logic                 r_ovf;

  // Out of range exactly when the bits above the result sign are not a pure sign extension.
  always_comb begin
    w_hi  = w_acc_next[ACC_W-1:OUT_W-1];
    w_ovf = (w_hi != {(ACC_W-OUT_W+1){1'b0}}) && (w_hi != {(ACC_W-OUT_W+1){1'b1}});
    if (!w_ovf) begin
      w_out_sum = w_acc_next[OUT_W-1:0];
    end else if (w_acc_next[ACC_W-1]) begin
      w_out_sum = SAT_MIN;
    end else begin
      w_out_sum = SAT_MAX;
    end
  end

  assign out_ovf = r_ovf;
`else
  assign w_out_sum = w_acc_next[OUT_W-1:0];
`endif

  // Job FSM with valid pipe, chunk counter, accumulator and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_len       <= {CNT_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_vpipe     <= {(L+1){1'b0}};
      r_acc       <= {ACC_W{1'b0}};
      r_job_ready <= 1'b1;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_sum   <= {OUT_W{1'b0}};
`ifdef TSS_SAT_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_vpipe <= {r_vpipe[L-1:0], w_beat};
      if (r_vpipe[L]) begin
        r_acc <= w_acc_next;
      end
      case (r_state)
        IDLE: begin
          if (job_valid) begin
            r_len       <= job_len;
            r_cnt       <= {CNT_W{1'b0}};
            r_acc       <= {ACC_W{1'b0}};
            r_state     <= FEED;
            r_job_ready <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        FEED: begin
          if (w_beat) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == r_len) begin
              r_state    <= DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Only the top stage may still hold a beat: this edge lands the final add.
          if (r_vpipe[L-1:0] == {L{1'b0}}) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out_sum   <= w_out_sum;
`ifdef TSS_SAT_EN
            r_ovf       <= w_ovf;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_job_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_job_ready <= 1'b1;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign job_ready = r_job_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign busy      = r_busy;

endmodule

// File: tb/tb_tree_sum_sequencer.sv
// Self-checking bench for tree_sum_sequencer: default instance plus an OUT_W=12 twin driven in lockstep.
module tb_tree_sum_sequencer;

  localparam int LANES  = 16;
  localparam int IN_W   = 8;
  localparam int CHUNKS = 256;
  localparam int L      = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         job_valid = 1'b0;
  logic [7:0]   job_len = 8'd0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = 128'd0;
  logic         out_ready = 1'b0;

  logic         job_ready, in_ready, out_valid, busy;
  logic [19:0]  out_sum;
  logic         job_ready12, in_ready12, out_valid12, busy12;
  logic [11:0]  out_sum12;
`ifdef TSS_SAT_EN
  logic         out_ovf, out_ovf12;
`endif

  tree_sum_sequencer #(.LANES(LANES), .IN_W(IN_W), .CHUNKS(CHUNKS), .OUT_W(20)) u_dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef TSS_SAT_EN
    .out_ovf(out_ovf),
`endif
    .busy(busy)
  );

  tree_sum_sequencer #(.LANES(LANES), .IN_W(IN_W), .CHUNKS(CHUNKS), .OUT_W(12)) u_dut12 (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready12), .job_len(job_len),
    .in_valid(in_valid), .in_ready(in_ready12), .in_data(in_data),
    .out_valid(out_valid12), .out_ready(out_ready), .out_sum(out_sum12),
`ifdef TSS_SAT_EN
    .out_ovf(out_ovf12),
`endif
    .busy(busy12)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int base;
    int step;
    int gap;
    int hold;
    int exp;
  } vec_t;

  typedef struct {
    int s20;
    int s12;
    bit o12;
  } exp_t;

  vec_t vecs[6];
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input int s);
    exp_t e;
    e.s20 = s;
`ifdef TSS_SAT_EN
    if (s > 2047) begin
      e.s12 = 2047;
      e.o12 = 1'b1;
    end else if (s < -2048) begin
      e.s12 = -2048;
      e.o12 = 1'b1;
    end else begin
      e.s12 = s;
      e.o12 = 1'b0;
    end
`else
    e.s12 = int'($signed(12'(s)));
    e.o12 = 1'b0;
`endif
    return e;
  endfunction

  task automatic run_job(input vec_t v);
    exp_t         e;
    int           n;
    int           edges;
    logic [127:0] d;
    logic [7:0]   lv;
    for (int i = 0; i < LANES; i++) begin
      lv = 8'(v.base + i * v.step);
      d[i*8 +: 8] = lv;
    end
    n = 0;
    while (!job_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("job_ready_wait", job_ready, 1);
    job_valid = 1'b1;
    job_len   = 8'(v.len);
    @(posedge clk); #1;
    job_valid = 1'b0;
    sbq.push_back(mk_exp(v.exp));
    for (int b = 0; b <= v.len; b++) begin
      in_valid = 1'b0;
      repeat (v.gap) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      while (!in_ready && n < 20) begin
        @(posedge clk); #1; n++;
      end
      if (!in_ready) begin
        chk("beat_timeout", in_ready, 1);
        break;
      end
      @(posedge clk); #1;
    end
    // Junk beats and job requests while draining must be ignored.
    in_data   = {16{8'h7f}};
    in_valid  = 1'b1;
    job_valid = 1'b1;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1; edges++;
    end
    job_valid = 1'b0;
    in_valid  = 1'b0;
    chk("latency", edges, L + 1);
    out_ready = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      chk("hold_sum", $signed(out_sum), sbq[0].s20);
      chk("hold_flags", {job_ready, in_ready, out_valid, busy}, 4'b0011);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    e = sbq.pop_front();
    chk("out_valid", out_valid, 1);
    chk("out_sum", $signed(out_sum), e.s20);
    chk("out_valid12", out_valid12, 1);
    chk("out_sum12", $signed(out_sum12), e.s12);
`ifdef TSS_SAT_EN
    chk("out_ovf", out_ovf, 0);
    chk("out_ovf12", out_ovf12, e.o12);
`endif
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_handshake", {out_valid, job_ready, busy}, 3'b010);
  endtask

  initial begin
    vec_t v6;
    vecs[0] = '{0,    1,  0, 0,  0,     16};
    vecs[1] = '{3, -128,  0, 2,  0,  -8192};
    vecs[2] = '{255, -128, 0, 0,  0, -524288};
    vecs[3] = '{1,  127,  0, 0,  0,   4064};
    vecs[4] = '{2,   -8,  1, 1, 10,    -24};
    vecs[5] = '{4,  100,  9, 0,  0,  -1960};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_flags", {job_ready, in_ready, out_valid, busy}, 4'b1000);
    chk("reset_sum", out_sum, 0);
    chk("reset_flags12", {job_ready12, in_ready12, out_valid12, busy12}, 4'b1000);
`ifdef TSS_SAT_EN
    chk("reset_ovf", out_ovf, 0);
`endif

    for (int t = 0; t < 6; t++) begin
      run_job(vecs[t]);
    end

    // Abort after two of four beats, then in_valid in IDLE must not leak into the next job.
    job_valid = 1'b1;
    job_len   = 8'd3;
    @(posedge clk); #1;
    job_valid = 1'b0;
    in_valid  = 1'b1;
    in_data   = {16{8'h05}};
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_flags", {job_ready, in_ready, out_valid, busy}, 4'b1000);
    chk("abort_sum", out_sum, 0);
    in_valid = 1'b1;
    in_data  = {16{8'h33}};
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_ignores", {in_ready, busy, out_valid}, 3'b000);
    end
    in_valid = 1'b0;
    v6 = '{0, 2, 0, 0, 0, 32};
    run_job(v6);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
